// File: rtl/serial_topk_argmax_pkg.sv
// Shared types for the streaming top-K argmax block: FSM state encoding and sizing limits.
package serial_topk_argmax_pkg;

   typedef enum logic [0:0] {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_e;

   localparam int K_MAX = 8;

   function automatic bit signed_ge(input bit is_signed, input logic a_msb, input logic b_msb,
                                    input bit mag_ge);
      // Two's-complement ordering differs from unsigned only when the sign bits disagree.
      if (is_signed && (a_msb != b_msb)) return b_msb;
      return mag_ge;
   endfunction

endpackage

// File: rtl/serial_topk_argmax_slot.sv
// One rank cell of the top-K list: holds value/index/valid and reports whether it ranks at or above
// the incoming sample.
module topk_slot
   import serial_topk_argmax_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int IW     = 3,
   parameter int SIGNED = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             load_new,
   input  logic             load_above,
   input  logic [WIDTH-1:0] above_val,
   input  logic [IW-1:0]    above_idx,
   input  logic             above_vld,
   input  logic [WIDTH-1:0] new_val,
   input  logic [IW-1:0]    new_idx,
   output logic [WIDTH-1:0] val,
   output logic [IW-1:0]    idx,
   output logic             vld,
   output logic             ge
);

   logic mag_ge;

   assign mag_ge = (val >= new_val);
   // Strict ordering for the newcomer: an equal value already held keeps its rank.
   assign ge = vld && signed_ge(SIGNED != 0, val[WIDTH-1], new_val[WIDTH-1], mag_ge);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         val <= '0;
         idx <= '0;
         vld <= 1'b0;
      end else if (clr) begin
         val <= '0;
         idx <= '0;
         vld <= 1'b0;
      end else if (load_new) begin
         val <= new_val;
         idx <= new_idx;
         vld <= 1'b1;
      end else if (load_above) begin
         val <= above_val;
         idx <= above_idx;
         vld <= above_vld;
      end
   end

endmodule

// File: rtl/serial_topk_argmax.sv
// Streaming top-K argmax over framed samples with rank-ordered result handshake.
// Optional out_val port enabled by defining SERIAL_TOPK_ARGMAX_VALUES_EN.
//
// state    | meaning
// ST_ACCUM | accepting samples, updating the rank list
// ST_HOLD  | result presented on out_*, waiting for out_ready
module serial_topk_argmax
   import serial_topk_argmax_pkg::*;
#(
   parameter int WIDTH        = 8,
   parameter int ARGMAX_WIDTH = 3,
   parameter int K            = 2,
   parameter int SIGNED       = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH-1:0]          in_data,
   input  logic                      in_valid,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic [K*ARGMAX_WIDTH-1:0] out_idx,
   output logic [K-1:0]              out_mask,
   output logic                      out_overflow,
   output logic                      out_valid,
   input  logic                      out_ready
`ifdef SERIAL_TOPK_ARGMAX_VALUES_EN
   ,
   output logic [K*WIDTH-1:0]        out_val
`endif
);

   localparam int AW = ARGMAX_WIDTH;
   localparam logic [AW-1:0] IDX_MAX = '1;

   state_e          state;
   logic [AW-1:0]   idx_cnt;
   logic            sat;
   logic            overflow;
   logic            accept;
   logic            clr;

   logic [K-1:0]    ge;
   logic [K-1:0]    load_new;
   logic [K-1:0]    load_above;
   logic [WIDTH-1:0] slot_val [K];
   logic [AW-1:0]    slot_idx [K];
   logic [K-1:0]     slot_vld;
   logic [WIDTH-1:0] up_val [K];
   logic [AW-1:0]    up_idx [K];
   logic [K-1:0]     up_vld;

   assign in_ready     = !out_valid;
   assign accept       = in_valid && in_ready;
   assign clr          = out_valid && out_ready;
   assign out_overflow = overflow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ST_ACCUM;
         idx_cnt   <= '0;
         sat       <= 1'b0;
         overflow  <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: begin
               if (accept) begin
                  // sat marks that the last index has been used; any beat after that overflows.
                  if (idx_cnt != IDX_MAX) begin
                     idx_cnt <= idx_cnt + 1'b1;
                  end else begin
                     sat      <= 1'b1;
                     overflow <= overflow | sat;
                  end
                  if (in_last) begin
                     state     <= ST_HOLD;
                     out_valid <= 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (out_ready) begin
                  state     <= ST_ACCUM;
                  out_valid <= 1'b0;
                  idx_cnt   <= '0;
                  sat       <= 1'b0;
                  overflow  <= 1'b0;
               end
            end
            default: begin
               state     <= ST_ACCUM;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   // The ge flags form a thermometer (list is sorted, valid entries contiguous), so the
   // insertion point p is the first clear flag; slots below p shift down by one.
   for (genvar r = 0; r < K; r++) begin : g_rank
      if (r == 0) begin : g_first
         assign up_val[r]     = '0;
         assign up_idx[r]     = '0;
         assign up_vld[r]     = 1'b0;
         assign load_new[r]   = accept && !ge[r];
         assign load_above[r] = 1'b0;
      end else begin : g_next
         assign up_val[r]     = slot_val[r-1];
         assign up_idx[r]     = slot_idx[r-1];
         assign up_vld[r]     = slot_vld[r-1];
         assign load_new[r]   = accept && ge[r-1] && !ge[r];
         assign load_above[r] = accept && !ge[r-1];
      end

      topk_slot #(
         .WIDTH  (WIDTH),
         .IW     (AW),
         .SIGNED (SIGNED)
      ) u_slot (
         .clk        (clk),
         .rst        (rst),
         .clr        (clr),
         .load_new   (load_new[r]),
         .load_above (load_above[r]),
         .above_val  (up_val[r]),
         .above_idx  (up_idx[r]),
         .above_vld  (up_vld[r]),
         .new_val    (in_data),
         .new_idx    (idx_cnt),
         .val        (slot_val[r]),
         .idx        (slot_idx[r]),
         .vld        (slot_vld[r]),
         .ge         (ge[r])
      );

      assign out_idx[r*AW +: AW] = slot_idx[r];
      assign out_mask[r]         = slot_vld[r];
`ifdef SERIAL_TOPK_ARGMAX_VALUES_EN
      assign out_val[r*WIDTH +: WIDTH] = slot_val[r];
`endif
   end

endmodule
